// File: rtl/wakey_wakey_pkg.sv
// Shared definitions for the wake-word front end: output width, FSM states
// and the accumulator helper used by the PDM decimator.
package wakey_wakey_pkg;

    localparam int DFE_OUTPUT_BW = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } fsm_state_t;

    function automatic logic [DFE_OUTPUT_BW-1:0] add_sample(
        input logic [DFE_OUTPUT_BW-1:0] acc,
        input logic                     sample
    );
        return acc + {{(DFE_OUTPUT_BW-1){1'b0}}, sample};
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync2 (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Capture the asynchronous input and resolve metastability over two stages.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/pdm_frontend.sv
// PDM microphone front end: generates the mic clock, counts ones per
// decimation window and strobes each completed window once warmup is over.
module pdm_frontend
    import wakey_wakey_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int DECIM_LEN  = 250,
    parameter int WARMUP_WIN = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     pdm_data_i,
    input  logic                     vad_i,
    output logic                     pdm_clk_o,
    output logic [DFE_OUTPUT_BW-1:0] dfe_data,
    output logic                     dfe_valid
);

    if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
        $error("pdm_frontend: CLK_DIV must be within 2..255");
    end
    if (DECIM_LEN < 1 || DECIM_LEN > 255) begin : g_bad_decim_len
        $error("pdm_frontend: DECIM_LEN must be within 1..255");
    end
    if (WARMUP_WIN < 0 || WARMUP_WIN > 15) begin : g_bad_warmup_win
        $error("pdm_frontend: WARMUP_WIN must be within 0..15");
    end

    localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0]  DECIM_LAST = 8'(DECIM_LEN - 1);
    localparam logic [3:0]  WARM_LAST  = 4'(WARMUP_WIN - 1);
    localparam fsm_state_t  FIRST_ACTIVE = (WARMUP_WIN > 0) ? ST_WARMUP : ST_RUN;

    logic pdm_s;
    logic vad_s;

    sync2 u_sync_pdm (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d       (pdm_data_i),
        .q       (pdm_s)
    );

    sync2 u_sync_vad (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d       (vad_i),
        .q       (vad_s)
    );

    fsm_state_t               state_r;
    logic [7:0]               div_cnt_r;
    logic [7:0]               sample_cnt_r;
    logic [DFE_OUTPUT_BW-1:0] acc_r;
    logic [3:0]               warm_cnt_r;
    logic                     pdm_clk_r;
    logic [DFE_OUTPUT_BW-1:0] dfe_data_r;
    logic                     dfe_valid_r;

    // Control FSM, clock divider, window accumulator and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r      <= ST_IDLE;
            div_cnt_r    <= 8'd0;
            sample_cnt_r <= 8'd0;
            acc_r        <= '0;
            warm_cnt_r   <= 4'd0;
            pdm_clk_r    <= 1'b0;
            dfe_data_r   <= '0;
            dfe_valid_r  <= 1'b0;
        end else begin
            dfe_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    div_cnt_r    <= 8'd0;
                    sample_cnt_r <= 8'd0;
                    acc_r        <= '0;
                    warm_cnt_r   <= 4'd0;
                    pdm_clk_r    <= 1'b0;
                    if (vad_s) begin
                        state_r <= FIRST_ACTIVE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WARMUP, ST_RUN: begin
                    // A dropped enable wins over everything, including a window
                    // completing in this same cycle.
                    if (!vad_s) begin
                        state_r      <= ST_IDLE;
                        div_cnt_r    <= 8'd0;
                        sample_cnt_r <= 8'd0;
                        acc_r        <= '0;
                        warm_cnt_r   <= 4'd0;
                        pdm_clk_r    <= 1'b0;
                    end else if (div_cnt_r == DIV_LAST) begin
                        div_cnt_r <= 8'd0;
                        pdm_clk_r <= ~pdm_clk_r;
                        if (!pdm_clk_r) begin
                            if (sample_cnt_r == DECIM_LAST) begin
                                sample_cnt_r <= 8'd0;
                                acc_r        <= '0;
                                if (state_r == ST_RUN) begin
                                    dfe_data_r  <= add_sample(acc_r, pdm_s);
                                    dfe_valid_r <= 1'b1;
                                end else begin
                                    warm_cnt_r <= warm_cnt_r + 4'd1;
                                    if (warm_cnt_r == WARM_LAST) begin
                                        state_r <= ST_RUN;
                                    end else begin
                                        state_r <= ST_WARMUP;
                                    end
                                end
                            end else begin
                                sample_cnt_r <= sample_cnt_r + 8'd1;
                                acc_r        <= add_sample(acc_r, pdm_s);
                            end
                        end else begin
                            sample_cnt_r <= sample_cnt_r;
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    div_cnt_r    <= 8'd0;
                    sample_cnt_r <= 8'd0;
                    acc_r        <= '0;
                    warm_cnt_r   <= 4'd0;
                    pdm_clk_r    <= 1'b0;
                end
            endcase
        end
    end

    assign pdm_clk_o = pdm_clk_r;
    assign dfe_data  = dfe_data_r;
    assign dfe_valid = dfe_valid_r;

endmodule

// File: tb/tb_pdm_frontend.sv
// Self-checking bench for pdm_frontend with an arithmetic timing/ones-count model.
module tb_pdm_frontend;

    localparam int CLK_DIV    = 4;
    localparam int DECIM_LEN  = 8;
    localparam int WARMUP_WIN = 1;
    localparam int NEVER      = 1 << 30;

    logic       clk_i;
    logic       rst_n_i;
    logic       pdm_data_i;
    logic       vad_i;
    logic       pdm_clk_o;
    logic [7:0] dfe_data;
    logic       dfe_valid;

    pdm_frontend #(
        .CLK_DIV    (CLK_DIV),
        .DECIM_LEN  (DECIM_LEN),
        .WARMUP_WIN (WARMUP_WIN)
    ) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .pdm_data_i (pdm_data_i),
        .vad_i      (vad_i),
        .pdm_clk_o  (pdm_clk_o),
        .dfe_data   (dfe_data),
        .dfe_valid  (dfe_valid)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          en       = 1'b0;
    int          e0       = 0;
    int          f0       = NEVER;
    int          mode     = 0;
    logic [31:0] exp_data = 32'd0;
    bit          hist [int];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Edge of the m-th rising pdm clock after enabling at edge e0.
    function automatic int rise(input int m);
        return e0 + 3 + CLK_DIV + (m - 1) * 2 * CLK_DIV;
    endfunction

    function automatic int win_sum(input int n);
        int s = 0;
        for (int m = n - DECIM_LEN + 1; m <= n; m++) s += int'(hist[rise(m) - 3]);
        return s;
    endfunction

    task automatic check_cycle();
        logic [31:0] ec;
        logic [31:0] ev;
        int d;
        int n;
        ec = 32'd0;
        ev = 32'd0;
        if (rst_n_i !== 1'b1) begin
            exp_data = 32'd0;
        end else if (en && cyc >= e0 + 3 && cyc <= f0 + 2) begin
            d  = cyc - e0 - 3;
            ec = 32'((d / CLK_DIV) % 2);
            if (d >= CLK_DIV && ((d - CLK_DIV) % (2 * CLK_DIV)) == 0) begin
                n = (d - CLK_DIV) / (2 * CLK_DIV) + 1;
                if (n > WARMUP_WIN * DECIM_LEN && (n % DECIM_LEN) == 0) begin
                    ev       = 32'd1;
                    exp_data = 32'(win_sum(n));
                end
            end
        end
        chk("pdm_clk", {31'd0, pdm_clk_o}, ec);
        chk("dfe_valid", {31'd0, dfe_valid}, ev);
        chk("dfe_data", {24'd0, dfe_data}, exp_data);
    endtask

    task automatic step();
        @(posedge clk_i);
        cyc++;
        #1;
        check_cycle();
    endtask

    task automatic drive_data();
        case (mode)
            0:       pdm_data_i = 1'b1;
            1:       pdm_data_i = 1'b0;
            2:       pdm_data_i = 1'((cyc / (2 * CLK_DIV)) % 2);
            default: pdm_data_i = 1'($urandom_range(1, 0));
        endcase
        hist[cyc] = pdm_data_i;
    endtask

    task automatic run(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            step();
            drive_data();
        end
    endtask

    initial begin
        int n;
        rst_n_i    = 1'b0;
        vad_i      = 1'b0;
        pdm_data_i = 1'b0;
        hist[0]    = 1'b0;

        // Reset held while inputs toggle: outputs must stay at zero.
        for (int i = 0; i < 10; i++) begin
            step();
            vad_i = 1'($urandom_range(1, 0));
            mode  = 3;
            drive_data();
        end
        vad_i   = 1'b0;
        rst_n_i = 1'b1;
        run(6);

        // Constant ones: warmup window then a count of 8 every 64 cycles.
        mode  = 0;
        vad_i = 1'b1;
        en    = 1'b1;
        e0    = cyc;
        f0    = NEVER;
        run(3 + CLK_DIV + 16 * 2 * CLK_DIV + 3 * 64 + 5);

        // Alternating, all-zero and random sample patterns.
        mode = 2;
        run(200);
        mode = 1;
        run(150);
        mode = 3;
        run(200);

        // Drop enable right after the 5th sample of a RUN window.
        n = WARMUP_WIN * DECIM_LEN + 5;
        while (rise(n) <= cyc) n += DECIM_LEN;
        run(rise(n) - cyc);
        vad_i = 1'b0;
        f0    = cyc;
        run(3);
        chk("drop_clk_low", {31'd0, pdm_clk_o}, 32'd0);
        run(60);

        // Re-enable: full warmup repeats before the first valid.
        vad_i = 1'b1;
        e0    = cyc;
        f0    = NEVER;
        run(3 + CLK_DIV + 16 * 2 * CLK_DIV + 37);

        // Reset pulse mid-RUN clears outputs at once, then warmup restarts.
        rst_n_i  = 1'b0;
        en       = 1'b0;
        exp_data = 32'd0;
        #1;
        chk("rst_clk_now", {31'd0, pdm_clk_o}, 32'd0);
        chk("rst_valid_now", {31'd0, dfe_valid}, 32'd0);
        chk("rst_data_now", {24'd0, dfe_data}, 32'd0);
        run(4);
        rst_n_i = 1'b1;
        en      = 1'b1;
        e0      = cyc;
        run(3 + CLK_DIV + 16 * 2 * CLK_DIV + 80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
